// File: rtl/mxrv_div.sv
// mxrv_div: multi-cycle RV32M divider for DIV, DIVU, REM and REMU.
// Each accepted request produces one result pulse tagged with its destination register.
// A request takes a START cycle, then 32 restoring-division steps (one quotient bit
// per cycle, MSB first), then an END cycle that applies the signs and presents the result.
// Zero divisor, signed overflow and non-divide codes skip CALC and go straight to END.
module mxrv_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [31:0] result_o,
    output logic [4:0]  reg_waddr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_CALC  = 2'd2,
        S_END   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;           // funct3: [2]=divide, [1]=remainder, [0]=unsigned
    logic [31:0] a_q, a_d;             // dividend; becomes magnitude, then shifts out MSB first
    logic [31:0] b_q, b_d;             // divisor; becomes magnitude in START
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] quot_q, quot_d;
    logic [32:0] rem_q, rem_d;         // partial remainder
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        special_q, special_d;  // result bypasses CALC
    logic [31:0] special_res_q, special_res_d;
    logic        busy_q, busy_d;

    // Datapath helpers
    logic        is_signed;
    logic [33:0] rem_shift;
    logic [33:0] trial;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_res;

    assign is_signed = ~op_q[0];

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        rem_shift = {rem_q, a_q[31]};
        trial     = rem_shift - {2'b00, b_q};
    end

    // Signed fix-up and result selection for the END cycle
    always_comb begin
        quot_fix  = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
        rem_fix   = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        if (special_q) begin
            final_res = special_res_q;
        end else begin
            final_res = op_q[1] ? rem_fix : quot_fix;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        // NOTE: every value written here is defaulted first so no path leaves a latch.
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        waddr_d       = waddr_q;
        quot_d        = quot_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        neg_quot_d    = neg_quot_q;
        neg_rem_d     = neg_rem_q;
        special_d     = special_q;
        special_res_d = special_res_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    a_d     = dividend_i;
                    b_d     = divisor_i;
                    waddr_d = reg_waddr_i;
                    state_d = S_START;
                end
            end

            S_START: begin
                special_d = 1'b1;
                if (b_q == 32'd0) begin
                    special_res_d = op_q[1] ? a_q : 32'hFFFF_FFFF;
                    state_d       = S_END;
                end else if (op_q[2] && is_signed && (a_q == 32'h8000_0000) &&
                             (b_q == 32'hFFFF_FFFF)) begin
                    special_res_d = op_q[1] ? 32'd0 : 32'h8000_0000;
                    state_d       = S_END;
                end else if (!op_q[2]) begin
                    special_res_d = 32'd0;
                    state_d       = S_END;
                end else begin
                    special_d  = 1'b0;
                    neg_quot_d = is_signed && (a_q[31] ^ b_q[31]);
                    neg_rem_d  = is_signed && a_q[31];
                    a_d        = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
                    b_d        = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
                    quot_d     = 32'd0;
                    rem_d      = 33'd0;
                    cnt_d      = 5'd0;
                    state_d    = S_CALC;
                end
            end

            S_CALC: begin
                a_d = {a_q[30:0], 1'b0};
                if (!trial[33]) begin
                    rem_d  = trial[32:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[32:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_END;
                end
            end

            S_END: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle request in IDLE
        if (flush_i) begin
            state_d = S_IDLE;
        end

        busy_d = (state_d == S_START) || (state_d == S_CALC);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            waddr_q       <= 5'd0;
            quot_q        <= 32'd0;
            rem_q         <= 33'd0;
            cnt_q         <= 5'd0;
            neg_quot_q    <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= 32'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            waddr_q       <= waddr_d;
            quot_q        <= quot_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            neg_quot_q    <= neg_quot_d;
            neg_rem_q     <= neg_rem_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
            busy_q        <= busy_d;
        end
    end

    // Outputs: result and tag are only visible during an unflushed END cycle
    always_comb begin
        busy_o      = busy_q;
        ready_o     = (state_q == S_END) && !flush_i;
        result_o    = ready_o ? final_res : 32'd0;
        reg_waddr_o = ready_o ? waddr_q : 5'd0;
    end

endmodule

// File: tb/tb_mxrv_div.sv
// tb_mxrv_div: directed checks of the RV32M divider with hand-computed expectations.
module tb_mxrv_div;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int vectors;
    int miscompares;

    mxrv_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa);
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    // Counts cycles after acceptance until ready_o, with a cycle budget.
    task automatic wait_ready(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (ready_o !== 1'b1 && lat < 100) begin
            if (busy_o === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int bc;
        issue(op, a, b, wa);
        wait_ready(lat, bc);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_waddr"}, {27'd0, reg_waddr_o}, {27'd0, wa});
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, ready_o}, 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int n;
        int seen;
        int extra;
        logic [31:0] r;
        logic [4:0]  w;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        op_i        = 3'd0;
        dividend_i  = 32'd0;
        divisor_i   = 32'd0;
        reg_waddr_i = 5'd0;
        flush_i     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_res",   result_o, 32'd0);
        check("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned divide with latency and busy window
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
        wait_ready(lat, bc);
        check("divu_lat",   lat, 34);
        check("divu_busy",  bc, 33);
        check("divu_res",   result_o, 32'd14);
        check("divu_waddr", {27'd0, reg_waddr_o}, 32'd5);
        check("divu_end_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        check("divu_pulse", {31'd0, ready_o}, 32'd0);

        // Signed operations
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 34);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 34);
        run_op("div_100_m7", OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd3, 32'hFFFF_FFF2, 34);
        run_op("rem_100_m7", OP_REM,  32'd100, 32'hFFFF_FFF9, 5'd4, 32'd2, 34);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 34);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 34);

        // Zero divisor and signed overflow take the short path
        run_op("div_by0",  OP_DIV,  32'd1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 2);
        run_op("remu_by0", OP_REMU, 32'd1234, 32'd0, 5'd8, 32'd1234, 2);
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 2);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 2);

        // Flush mid-CALC, then an immediate new request
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd11);
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        check("flush_busy_before", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy_after",  {31'd0, busy_o}, 32'd0);
        check("flush_ready_after", {31'd0, ready_o}, 32'd0);
        run_op("after_flush", OP_DIVU, 32'd9, 32'd3, 5'd12, 32'd3, 34);

        // Flush during END suppresses that cycle's pulse
        issue(OP_DIVU, 32'd1234, 32'd0, 5'd13);
        @(negedge clk);
        check("endflush_ready_pre", {31'd0, ready_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("endflush_ready", {31'd0, ready_o}, 32'd0);
        check("endflush_res",   result_o, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        check("endflush_idle_ready", {31'd0, ready_o}, 32'd0);

        // Flush and start together in IDLE: request dropped
        flush_i = 1'b1;
        issue(OP_DIVU, 32'd9, 32'd0, 5'd14);
        flush_i = 1'b0;
        check("fs_busy", {31'd0, busy_o}, 32'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready_o === 1'b1) extra++;
        end
        check("fs_no_ready", extra, 0);

        // start_i held every cycle while running: only the first is taken
        start_i     = 1'b1;
        op_i        = OP_DIVU;
        dividend_i  = 32'd50;
        divisor_i   = 32'd5;
        reg_waddr_i = 5'd3;
        n    = 0;
        seen = 0;
        r    = 32'd0;
        w    = 5'd0;
        while (seen == 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (ready_o === 1'b1) begin
                seen    = 1;
                r       = result_o;
                w       = reg_waddr_o;
                start_i = 1'b0;
            end else begin
                dividend_i  = $urandom;
                divisor_i   = $urandom_range(1, 100);
                reg_waddr_i = 5'($urandom_range(0, 31));
                op_i        = 3'($urandom_range(4, 7));
            end
        end
        start_i = 1'b0;
        check("spam_lat",   n, 34);
        check("spam_res",   r, 32'd10);
        check("spam_waddr", {27'd0, w}, 32'd3);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1) extra++;
        end
        check("spam_single_ready", extra, 0);

        // Asynchronous reset mid-CALC
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd15);
        repeat (10) @(negedge clk);
        check("arst_busy_pre", {31'd0, busy_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy_o}, 32'd0);
        check("arst_ready", {31'd0, ready_o}, 32'd0);
        check("arst_res",   result_o, 32'd0);
        check("arst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1 || busy_o === 1'b1) extra++;
        end
        check("arst_quiet", extra, 0);
        run_op("after_rst", OP_DIVU, 32'd9, 32'd3, 5'd16, 32'd3, 34);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
